sdram_port_arbiter: RTL and testbench

Two-master arbiter in front of the SDRAM controller's Avalon-MM s1 port, on the controller's clock domain. Master 0 is the display line fetcher (read-only, high priority); master 1 is the frame loader (SD-card or test writer, read/write). The arbiter grants the slave port in bounded bursts, tracks outstanding reads in a tag FIFO, and routes each returned read word to the master that issued it.

---
 rtl/sdram_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-master burst arbiter with read tag FIFO for SDRAM s1 port
module sdram_port_arbiter #(
  parameter int MAX_PENDING = 8,
  parameter int BURST_LEN   = 16
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iM0_READ,
  input  logic [24:0] iM0_ADDR,
  output logic        oM0_WAITREQ,
  output logic [15:0] oM0_RDATA,
  output logic        oM0_RDVALID,
  input  logic        iM1_READ,
  input  logic        iM1_WRITE,
  input  logic [24:0] iM1_ADDR,
  input  logic [15:0] iM1_WDATA,
  output logic        oM1_WAITREQ,
  output logic [15:0] oM1_RDATA,
  output logic        oM1_RDVALID,
  output logic [24:0] oS_ADDR,
  output logic [15:0] oS_WDATA,
  output logic        oS_READ,
  output logic        oS_WRITE,
  input  logic        iS_WAITREQ,
  input  logic [15:0] iS_RDATA,
  input  logic        iS_RDVALID,
  output logic [1:0]  oGRANT,
  output logic        oERR
);
  localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;

  logic          rst_meta, rst_sync;
  state_t        state;
  logic [BW-1:0] burst, burst_next;
  logic [MAX_PENDING-1:0] tag_mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] pending;
  logic          m0_req, m1_req, m1_rd, cmd_read, read_block;
  logic          accept, push, pop, at_limit, head_tag;
  logic          rv0, rv1, err;
  logic [15:0]   rdata;

  // Reset asserts asynchronously and releases two iCLK edges later
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  assign m0_req = iM0_READ;
  assign m1_req = iM1_READ | iM1_WRITE;
  // Both strobes high from master 1 is a protocol error; the write wins
  assign m1_rd  = iM1_READ & ~iM1_WRITE;

  // A slot freed by a return this cycle is immediately usable by a new read
  assign cmd_read   = ((state == G0) & m0_req) | ((state == G1) & m1_rd);
  assign read_block = cmd_read & (pending == CW'(MAX_PENDING)) & ~iS_RDVALID;

  assign oGRANT      = state;
  assign oS_READ     = cmd_read & ~read_block;
  assign oS_WRITE    = (state == G1) & iM1_WRITE;
  assign oS_ADDR     = (state == G0) ? iM0_ADDR : (state == G1) ? iM1_ADDR : 25'd0;
  assign oS_WDATA    = (state == G1) ? iM1_WDATA : 16'd0;
  assign oM0_WAITREQ = (state == G0) ? (iS_WAITREQ | read_block) : 1'b1;
  assign oM1_WAITREQ = (state == G1) ? (iS_WAITREQ | read_block) : 1'b1;

  assign accept     = (oS_READ | oS_WRITE) & ~iS_WAITREQ;
  assign push       = accept & oS_READ;
  assign pop        = iS_RDVALID & (pending != '0);
  assign head_tag   = tag_mem[rd_ptr];
  assign burst_next = (accept && burst != BW'(BURST_LEN)) ? burst + 1'b1 : burst;
  assign at_limit   = (burst_next == BW'(BURST_LEN));

  // Grant FSM: priority to master 0 from idle, forced switch after a full burst
  always_ff @(posedge iCLK or negedge rst_sync) begin
    if (!rst_sync) begin
      state <= IDLE;
      burst <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst <= '0;
          if (m0_req)      state <= G0;
          else if (m1_req) state <= G1;
        end
        G0: begin
          if (!m0_req) begin
            state <= m1_req ? G1 : IDLE;
            burst <= '0;
          end else if (at_limit && m1_req) begin
            state <= G1;
            burst <= '0;
          end else begin
            burst <= burst_next;
          end
        end
        G1: begin
          if (!m1_req) begin
            state <= m0_req ? G0 : IDLE;
            burst <= '0;
          end else if (at_limit && m0_req) begin
            state <= G0;
            burst <= '0;
          end else begin
            burst <= burst_next;
          end
        end
        default: begin
          state <= IDLE;
          burst <= '0;
        end
      endcase
    end
  end

  // Tag FIFO remembers which master issued each outstanding read
  always_ff @(posedge iCLK or negedge rst_sync) begin
    if (!rst_sync) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= (state == G1);
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  // Returned data is registered once and strobed only to the issuing master
  always_ff @(posedge iCLK or negedge rst_sync) begin
    if (!rst_sync) begin
      rv0   <= 1'b0;
      rv1   <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      rv0 <= pop & ~head_tag;
      rv1 <= pop & head_tag;
      if (iS_RDVALID) rdata <= iS_RDATA;
      if (iS_RDVALID && pending == '0) err <= 1'b1;
    end
  end

  assign oM0_RDVALID = rv0;
  assign oM1_RDVALID = rv1;
  assign oM0_RDATA   = rdata;
  assign oM1_RDATA   = rdata;
  assign oERR        = err;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - randomized model-checked bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
  localparam int MAXP = 8;
  localparam int BL   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iM0_READ = 0, iM1_READ = 0, iM1_WRITE = 0;
  logic [24:0] iM0_ADDR = 0, iM1_ADDR = 0;
  logic [15:0] iM1_WDATA = 0, iS_RDATA = 0;
  logic        iS_WAITREQ = 0, iS_RDVALID = 0;
  logic        oM0_WAITREQ, oM0_RDVALID, oM1_WAITREQ, oM1_RDVALID;
  logic [15:0] oM0_RDATA, oM1_RDATA, oS_WDATA;
  logic [24:0] oS_ADDR;
  logic        oS_READ, oS_WRITE, oERR;
  logic [1:0]  oGRANT;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.MAX_PENDING(MAXP), .BURST_LEN(BL)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iM0_READ(iM0_READ), .iM0_ADDR(iM0_ADDR), .oM0_WAITREQ(oM0_WAITREQ),
    .oM0_RDATA(oM0_RDATA), .oM0_RDVALID(oM0_RDVALID),
    .iM1_READ(iM1_READ), .iM1_WRITE(iM1_WRITE), .iM1_ADDR(iM1_ADDR),
    .iM1_WDATA(iM1_WDATA), .oM1_WAITREQ(oM1_WAITREQ),
    .oM1_RDATA(oM1_RDATA), .oM1_RDVALID(oM1_RDVALID),
    .oS_ADDR(oS_ADDR), .oS_WDATA(oS_WDATA), .oS_READ(oS_READ), .oS_WRITE(oS_WRITE),
    .iS_WAITREQ(iS_WAITREQ), .iS_RDATA(iS_RDATA), .iS_RDVALID(iS_RDVALID),
    .oGRANT(oGRANT), .oERR(oERR)
  );

  typedef struct {int due; logic [15:0] d;} ret_t;

  int checks = 0, errors = 0, cyc = 0;
  // stimulus controls
  int m0_left = 0, m1_left = 0, m1_mode = 0, lat_min = 3, lat_max = 3, wait_pct = 0;
  bit gaps = 0, inject_rv = 0, chk_en = 0;
  logic m0_hold = 0, m1_hold = 0, m1_cr = 0, m1_cw = 0;
  logic [24:0] m0_addr = 0, m1_addr = 0;
  logic [15:0] m1_wd = 0;
  ret_t sq[$];
  // reference model
  int mg = 0, mburst = 0;
  int tagq[$];
  bit e_rv0 = 0, e_rv1 = 0, e_err = 0;
  logic [15:0] e_rdata = 0;
  // scoreboards and logs
  logic [24:0] a0q[$], a1q[$];
  int acc_log[$], route_log[$];
  int rv0_cnt = 0, rv1_cnt = 0, last_grant = 0;
  bit p3_track = 0, p3_seen = 0;
  int p3_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem(input logic [24:0] a);
    return 16'(a * 7 + 3) ^ 16'(a >> 9);
  endfunction

  task automatic model_reset();
    mg = 0; mburst = 0; tagq.delete();
    e_rv0 = 0; e_rv1 = 0; e_rdata = 0; e_err = 0;
  endtask

  task automatic drive();
    int r;
    if (!m0_hold && m0_left > 0 && (!gaps || $urandom_range(2, 0) != 0)) begin
      m0_hold = 1;
      if (gaps) m0_addr = 25'($urandom);
    end
    if (!m1_hold && m1_left > 0 && (!gaps || $urandom_range(2, 0) != 0)) begin
      m1_hold = 1;
      if (gaps) m1_addr = 25'($urandom);
      m1_wd = 16'($urandom);
      r = $urandom_range(9, 0);
      case (m1_mode)
        0: begin m1_cr = 1; m1_cw = 0; end
        1: begin m1_cr = 0; m1_cw = 1; end
        default: begin m1_cr = (r < 5) || (r == 9); m1_cw = (r >= 5); end
      endcase
    end
    iM0_READ  = m0_hold;
    iM0_ADDR  = m0_addr;
    iM1_READ  = m1_hold & m1_cr;
    iM1_WRITE = m1_hold & m1_cw;
    iM1_ADDR  = m1_addr;
    iM1_WDATA = m1_hold ? m1_wd : 16'($urandom);
    iS_WAITREQ = ($urandom_range(99, 0) < wait_pct);
    if (sq.size() > 0 && sq[0].due <= cyc) begin
      iS_RDVALID = 1; iS_RDATA = sq[0].d; void'(sq.pop_front());
    end else if (inject_rv) begin
      iS_RDVALID = 1; iS_RDATA = 16'($urandom);
    end else begin
      iS_RDVALID = 0; iS_RDATA = 16'($urandom);
    end
  endtask

  task automatic check_step();
    bit w0, w1, r1, cr, blk, x_rd, x_wr, x_w0, x_w1, acc, n_rv0, n_rv1;
    logic [24:0] x_addr;
    logic [15:0] x_wd;
    int nb, t;
    w0 = iM0_READ; w1 = iM1_READ | iM1_WRITE; r1 = iM1_READ & ~iM1_WRITE;
    cr  = (mg == 1) ? w0 : (mg == 2) ? r1 : 1'b0;
    blk = cr && tagq.size() == MAXP && !iS_RDVALID;
    x_rd = cr && !blk;
    x_wr = (mg == 2) && iM1_WRITE;
    x_addr = (mg == 1) ? iM0_ADDR : (mg == 2) ? iM1_ADDR : 25'd0;
    x_wd   = (mg == 2) ? iM1_WDATA : 16'd0;
    x_w0 = (mg == 1) ? (iS_WAITREQ || blk) : 1'b1;
    x_w1 = (mg == 2) ? (iS_WAITREQ || blk) : 1'b1;
    chk("grant", oGRANT, (mg == 1) ? 1 : (mg == 2) ? 2 : 0);
    chk("s_strobes", {oS_READ, oS_WRITE}, {x_rd, x_wr});
    chk("s_addr", oS_ADDR, x_addr);
    chk("s_wdata", oS_WDATA, x_wd);
    chk("waitreq", {oM1_WAITREQ, oM0_WAITREQ}, {x_w1, x_w0});
    chk("rdvalid", {oM1_RDVALID, oM0_RDVALID}, {e_rv1, e_rv0});
    chk("rdata", {oM1_RDATA, oM0_RDATA}, {e_rdata, e_rdata});
    chk("err", oERR, e_err);
    last_grant = oGRANT;
    // advance the model by one clock
    acc = (x_rd || x_wr) && !iS_WAITREQ;
    if (acc) acc_log.push_back(mg - 1);
    n_rv0 = 0; n_rv1 = 0;
    if (iS_RDVALID) begin
      e_rdata = iS_RDATA;
      if (tagq.size() > 0) begin
        t = tagq.pop_front();
        if (t == 0) n_rv0 = 1; else n_rv1 = 1;
      end else e_err = 1;
    end
    e_rv0 = n_rv0; e_rv1 = n_rv1;
    if (acc && x_rd) tagq.push_back(mg - 1);
    nb = mburst + ((acc && mburst < BL) ? 1 : 0);
    if (mg == 0) begin
      mburst = 0;
      mg = w0 ? 1 : w1 ? 2 : 0;
    end else begin
      if (!((mg == 1) ? w0 : w1)) begin
        mg = ((mg == 1) ? w1 : w0) ? 3 - mg : 0; mburst = 0;
      end else if (nb == BL && ((mg == 1) ? w1 : w0)) begin
        mg = 3 - mg; mburst = 0;
      end else mburst = nb;
    end
    // phase-3 accounting: reads accepted strictly before the first return
    if (p3_track) begin
      if (iS_RDVALID) p3_seen = 1;
      if (acc && !p3_seen) p3_cnt++;
    end
    // environment bookkeeping from what the DUT actually did
    if (iM0_READ && !oM0_WAITREQ) begin
      a0q.push_back(iM0_ADDR); m0_hold = 0; m0_left--;
      if (!gaps) m0_addr++;
    end
    if ((iM1_READ || iM1_WRITE) && !oM1_WAITREQ) begin
      if (iM1_READ && !iM1_WRITE) a1q.push_back(iM1_ADDR);
      m1_hold = 0; m1_left--;
      if (!gaps) m1_addr++;
    end
    if (oS_READ && !iS_WAITREQ) sq.push_back('{cyc + $urandom_range(lat_max, lat_min), mem(oS_ADDR)});
    if (oM0_RDVALID) begin
      rv0_cnt++; route_log.push_back(0);
      if (a0q.size() == 0) chk("m0_spurious", 1, 0);
      else chk("m0_data", oM0_RDATA, mem(a0q.pop_front()));
    end
    if (oM1_RDVALID) begin
      rv1_cnt++; route_log.push_back(1);
      if (a1q.size() == 0) chk("m1_spurious", 1, 0);
      else chk("m1_data", oM1_RDATA, mem(a1q.pop_front()));
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive();
      #1;
      if (chk_en) check_step();
      cyc++;
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (!(m0_left == 0 && m1_left == 0 && !m0_hold && !m1_hold && sq.size() == 0) && n < budget) begin
      cycle(1); n++;
    end
    if (n >= budget) chk({nm, "_timeout"}, n, 0);
    cycle(3);
  endtask

  task automatic reset_pins(input string nm);
    chk({nm, "_grant"}, oGRANT, 0);
    chk({nm, "_s_rw"}, {oS_READ, oS_WRITE}, 0);
    chk({nm, "_s_addr"}, oS_ADDR, 0);
    chk({nm, "_s_wdata"}, oS_WDATA, 0);
    chk({nm, "_waitreq"}, {oM1_WAITREQ, oM0_WAITREQ}, 2'b11);
    chk({nm, "_rdvalid"}, {oM1_RDVALID, oM0_RDVALID}, 0);
    chk({nm, "_rdata"}, {oM1_RDATA, oM0_RDATA}, 0);
    chk({nm, "_err"}, oERR, 0);
  endtask

  task automatic do_reset();
    chk_en = 0;
    m0_left = 0; m1_left = 0; m0_hold = 0; m1_hold = 0; inject_rv = 0;
    sq.delete(); a0q.delete(); a1q.delete();
    model_reset();
    cycle(2);
    @(negedge clk);
    rst_n = 1;
    cycle(3);
    chk_en = 1;
  endtask

  initial begin
    int v0, v1, ones;
    @(negedge clk); #1;
    reset_pins("reset0");
    do_reset();

    // 1: sixteen sequential M0 reads, latency 3
    lat_min = 3; lat_max = 3; wait_pct = 0; gaps = 0;
    m0_addr = 25'h100; m0_left = 16;
    cycle(1);
    chk("p1_grant_req_cycle", last_grant, 0);
    cycle(1);
    chk("p1_grant_next_cycle", last_grant, 1);
    drain("p1", 200);
    chk("p1_m0_strobes", rv0_cnt, 16);
    chk("p1_m1_strobes", rv1_cnt, 0);

    // 2: simultaneous requests, burst switching
    acc_log.delete();
    m0_addr = 25'h2000; m1_addr = 25'h3000; m1_mode = 1;
    m0_left = 40; m1_left = 16;
    drain("p2", 400);
    ones = 0;
    for (int i = 0; i < 32 && i < acc_log.size(); i++) if (acc_log[i] == 1) ones++;
    chk("p2_acc_count", acc_log.size(), 56);
    chk("p2_first", acc_log[0], 0);
    chk("p2_last_g0", acc_log[15], 0);
    chk("p2_first_g1", acc_log[16], 1);
    chk("p2_last_g1", acc_log[31], 1);
    chk("p2_back_g0", acc_log[32], 0);
    chk("p2_g1_count", ones, 16);

    // 3: long slave latency fills the tag FIFO
    lat_min = 20; lat_max = 20; m0_addr = 25'h4000; m0_left = 12;
    p3_track = 1; p3_seen = 0; p3_cnt = 0;
    drain("p3", 400);
    p3_track = 0;
    chk("p3_accepts_before_return", p3_cnt, MAXP);

    // 4: interleaved issuers, returns routed in issue order
    route_log.delete();
    m1_mode = 0; m1_addr = 25'h5000; m1_left = 3;
    for (int i = 0; i < 100 && m1_left > 0; i++) cycle(1);
    m0_addr = 25'h6000; m0_left = 2;
    drain("p4", 200);
    chk("p4_returns", route_log.size(), 5);
    if (route_log.size() == 5) begin
      chk("p4_r0", route_log[0], 1); chk("p4_r2", route_log[2], 1);
      chk("p4_r3", route_log[3], 0); chk("p4_r4", route_log[4], 0);
    end

    // 5: randomized traffic with both masters and stall noise
    gaps = 1; m1_mode = 2; lat_min = 1; lat_max = 8; wait_pct = 30;
    m0_left = 150; m1_left = 150;
    drain("p5", 5000);
    gaps = 0; wait_pct = 0;

    // 6: reset mid-traffic with five reads pending under G1
    lat_min = 20; lat_max = 20; m1_mode = 0; m1_addr = 25'h7000; m1_left = 10;
    for (int i = 0; i < 100 && m1_left > 5; i++) cycle(1);
    chk("p6_grant_before_reset", oGRANT, 2);
    @(negedge clk);
    rst_n = 0;
    #1;
    reset_pins("p6_reset");
    do_reset();
    v0 = rv0_cnt; v1 = rv1_cnt;
    lat_min = 3; lat_max = 3; m0_addr = 25'h1234; m0_left = 1;
    drain("p6_after", 100);
    chk("p6_m0_one_return", rv0_cnt - v0, 1);
    chk("p6_m1_none", rv1_cnt - v1, 0);

    // 7: return with nothing pending sets the sticky error
    v0 = rv0_cnt; v1 = rv1_cnt;
    inject_rv = 1; cycle(1); inject_rv = 0;
    cycle(5);
    chk("p7_err_sticky", oERR, 1);
    chk("p7_no_strobes", (rv0_cnt - v0) + (rv1_cnt - v1), 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("p7_err_cleared", oERR, 0);
    do_reset();
    cycle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
